dcache_port_arbiter: RTL

- Sequences the single data-cache port between two requesters:
  - pipeline loads from the MEM stage;
  - committed-store drains from the store buffer.
- Priority follows store-buffer occupancy, load starvation, and fence requests.
- Sits between MEM stage / store buffer and the data cache. Owns the cache request, address and data lines.

---
 rtl/dcache_port_arbiter_if.sv | 66 ++++++
 rtl/dcache_port_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/dcache_port_arbiter_if.sv
// rtl/dcache_port_arbiter_if.sv - request/cache signal bundle for dcache_port_arbiter; perf outputs exist only with ARB_PERF_CNT_EN
interface dcache_port_arbiter_if #(
    parameter int SB_SIZE = 4
);
    localparam int CNT_W = $clog2(SB_SIZE) + 1;

    logic             ld_req;
    logic [31:0]      ld_addr;
    logic [2:0]       ld_funct3;
    logic             ld_gnt;
    logic             ld_done;

    logic             st_req;
    logic [31:0]      st_addr;
    logic [31:0]      st_data;
    logic [2:0]       st_funct3;
    logic             st_pop;
    logic [CNT_W-1:0] sb_count;

    logic             fence_req;
    logic             fence_done;
    logic             flush;

    logic             cache_req;
    logic             cache_we;
    logic [31:0]      cache_addr;
    logic [31:0]      cache_wdata;
    logic [2:0]       cache_funct3;
    logic             cache_stall;

`ifdef ARB_PERF_CNT_EN
    logic [31:0]      perf_ld_cnt;
    logic [31:0]      perf_st_cnt;
    logic [31:0]      perf_stall_cnt;

    modport master (
        input  ld_req, ld_addr, ld_funct3, st_req, st_addr, st_data, st_funct3,
        input  sb_count, fence_req, flush, cache_stall,
        output ld_gnt, ld_done, st_pop, fence_done,
        output cache_req, cache_we, cache_addr, cache_wdata, cache_funct3,
        output perf_ld_cnt, perf_st_cnt, perf_stall_cnt
    );

    modport slave (
        output ld_req, ld_addr, ld_funct3, st_req, st_addr, st_data, st_funct3,
        output sb_count, fence_req, flush, cache_stall,
        input  ld_gnt, ld_done, st_pop, fence_done,
        input  cache_req, cache_we, cache_addr, cache_wdata, cache_funct3,
        input  perf_ld_cnt, perf_st_cnt, perf_stall_cnt
    );
`else
    modport master (
        input  ld_req, ld_addr, ld_funct3, st_req, st_addr, st_data, st_funct3,
        input  sb_count, fence_req, flush, cache_stall,
        output ld_gnt, ld_done, st_pop, fence_done,
        output cache_req, cache_we, cache_addr, cache_wdata, cache_funct3
    );

    modport slave (
        output ld_req, ld_addr, ld_funct3, st_req, st_addr, st_data, st_funct3,
        output sb_count, fence_req, flush, cache_stall,
        input  ld_gnt, ld_done, st_pop, fence_done,
        input  cache_req, cache_we, cache_addr, cache_wdata, cache_funct3
    );
`endif
endinterface

// File: rtl/dcache_port_arbiter.sv
// rtl/dcache_port_arbiter.sv - arbitrates the single dcache port between MEM-stage loads and store-buffer drains; ARB_PERF_CNT_EN adds perf counters
module dcache_port_arbiter #(
    parameter int SB_SIZE      = 4,
    parameter int DRAIN_THRESH = 3,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    dcache_port_arbiter_if.master bus
);
    localparam int CNT_W = $clog2(SB_SIZE) + 1;
    localparam int SCW   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] THRESH     = CNT_W'(DRAIN_THRESH);
    localparam logic [CNT_W-1:0] ONE_ENTRY  = CNT_W'(1);
    localparam logic [SCW-1:0]   STARVE_MAX = SCW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, LOAD, STORE, DRAIN} state_t;

    state_t         state;
    logic [SCW-1:0] starve_cnt;
    logic           ld_killed;
    logic           access_done;
    logic           store_first;

    assign access_done = bus.cache_req && !bus.cache_stall;
    // A flush in the completing cycle kills the result just like an earlier one.
    assign bus.ld_done = (state == LOAD) && access_done && !ld_killed && !bus.flush;
    assign bus.st_pop  = ((state == STORE) || (state == DRAIN)) && access_done;

    assign store_first = bus.st_req &&
                         ((bus.sb_count >= THRESH) || (starve_cnt == STARVE_MAX) || !bus.ld_req);

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            starve_cnt       <= '0;
            ld_killed        <= 1'b0;
            bus.ld_gnt       <= 1'b0;
            bus.fence_done   <= 1'b0;
            bus.cache_req    <= 1'b0;
            bus.cache_we     <= 1'b0;
            bus.cache_addr   <= '0;
            bus.cache_wdata  <= '0;
            bus.cache_funct3 <= '0;
        end else begin
            bus.ld_gnt     <= 1'b0;
            bus.fence_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.fence_req) begin
                        state <= DRAIN;
                    end else if (store_first) begin
                        state            <= STORE;
                        bus.cache_req    <= 1'b1;
                        bus.cache_we     <= 1'b1;
                        bus.cache_addr   <= bus.st_addr;
                        bus.cache_wdata  <= bus.st_data;
                        bus.cache_funct3 <= bus.st_funct3;
                    end else if (bus.ld_req && !bus.flush) begin
                        state            <= LOAD;
                        bus.ld_gnt       <= 1'b1;
                        bus.cache_req    <= 1'b1;
                        bus.cache_we     <= 1'b0;
                        bus.cache_addr   <= bus.ld_addr;
                        bus.cache_funct3 <= bus.ld_funct3;
                        ld_killed        <= 1'b0;
                    end
                end
                LOAD: begin
                    if (bus.flush) begin
                        ld_killed <= 1'b1;
                    end
                    if (!bus.cache_stall) begin
                        state         <= IDLE;
                        bus.cache_req <= 1'b0;
                        if (bus.st_req && (starve_cnt != STARVE_MAX)) begin
                            starve_cnt <= starve_cnt + SCW'(1);
                        end
                    end
                end
                STORE: begin
                    if (!bus.cache_stall) begin
                        state         <= IDLE;
                        bus.cache_req <= 1'b0;
                        starve_cnt    <= '0;
                    end
                end
                DRAIN: begin
                    // While popping, the store buffer already presents the entry behind the head.
                    if (bus.cache_req) begin
                        if (!bus.cache_stall) begin
                            starve_cnt <= '0;
                            if (bus.sb_count > ONE_ENTRY) begin
                                bus.cache_addr   <= bus.st_addr;
                                bus.cache_wdata  <= bus.st_data;
                                bus.cache_funct3 <= bus.st_funct3;
                            end else begin
                                bus.cache_req  <= 1'b0;
                                bus.fence_done <= 1'b1;
                                state          <= IDLE;
                            end
                        end
                    end else if (bus.st_req) begin
                        bus.cache_req    <= 1'b1;
                        bus.cache_we     <= 1'b1;
                        bus.cache_addr   <= bus.st_addr;
                        bus.cache_wdata  <= bus.st_data;
                        bus.cache_funct3 <= bus.st_funct3;
                    end else begin
                        bus.fence_done <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.perf_ld_cnt    <= '0;
            bus.perf_st_cnt    <= '0;
            bus.perf_stall_cnt <= '0;
        end else begin
            if ((state == LOAD) && access_done) begin
                bus.perf_ld_cnt <= bus.perf_ld_cnt + 32'd1;
            end
            if (bus.st_pop) begin
                bus.perf_st_cnt <= bus.perf_st_cnt + 32'd1;
            end
            if (bus.cache_req && bus.cache_stall) begin
                bus.perf_stall_cnt <= bus.perf_stall_cnt + 32'd1;
            end
        end
    end
`endif
endmodule
